// File: rtl/psum_accum_ctrl_if.sv
// OFIFO / PSUM-SRAM bus bundle for the partial-sum drain engine.
// The slave modport is the engine's view; the master modport is the environment's view.
interface psum_accum_ctrl_if #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ADDR_BW = 11
);
    logic                     start;
    logic [ADDR_BW-1:0]       base_addr;
    logic [ADDR_BW-1:0]       num_rows;
    logic                     acc_mode;
    logic                     relu_en;
    logic                     ofifo_valid;
    logic [COL*PSUM_BW-1:0]   ofifo_out;
    logic                     ofifo_rd;
    logic                     pmem_cen;
    logic                     pmem_wen;
    logic                     pmem_ren;
    logic [ADDR_BW-1:0]       pmem_addr;
    logic [COL*PSUM_BW-1:0]   pmem_d;
    logic [COL*PSUM_BW-1:0]   pmem_q;
    logic                     busy;
    logic                     done;

    modport slave (
        input  start, base_addr, num_rows, acc_mode, relu_en,
        input  ofifo_valid, ofifo_out, pmem_q,
        output ofifo_rd, pmem_cen, pmem_wen, pmem_ren, pmem_addr, pmem_d, busy, done
    );

    modport master (
        output start, base_addr, num_rows, acc_mode, relu_en,
        output ofifo_valid, ofifo_out, pmem_q,
        input  ofifo_rd, pmem_cen, pmem_wen, pmem_ren, pmem_addr, pmem_d, busy, done
    );
endinterface

// File: rtl/psum_accum_ctrl.sv
// Drains OFIFO rows into the PSUM SRAM, either overwriting or doing a per-row
// saturating read-modify-write, with optional ReLU on the written data.
module psum_accum_ctrl #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ADDR_BW = 11
) (
    input  logic               clk,
    input  logic               reset,
    psum_accum_ctrl_if.slave   bus
);
    localparam int W = PSUM_BW;

    typedef enum logic [1:0] {IDLE, FETCH, ADD, FINISH} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BW-1:0]   ptr_q, ptr_d;
    logic [ADDR_BW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [ADDR_BW-1:0]   nrows_q;
    logic                 acc_q, relu_q;
    logic [COL*W-1:0]     hold_q, hold_d;
    logic [COL*W-1:0]     wdata;

    // Write data: saturated sum in ADD, raw OFIFO row otherwise; ReLU last.
    for (genvar k = 0; k < COL; k++) begin : g_lane
        logic [W-1:0] h, q, src, sat;
        logic [W:0]   sum;
        assign h   = hold_q[k*W +: W];
        assign q   = bus.pmem_q[k*W +: W];
        assign sum = {h[W-1], h} + {q[W-1], q};
        always_comb begin
            if (sum[W] != sum[W-1])
                sat = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            else
                sat = sum[W-1:0];
        end
        assign src = (state_q == ADD) ? sat : bus.ofifo_out[k*W +: W];
        assign wdata[k*W +: W] = (relu_q && src[W-1]) ? '0 : src;
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        bus.ofifo_rd  = 1'b0;
        bus.pmem_cen  = 1'b1;
        bus.pmem_wen  = 1'b1;
        bus.pmem_ren  = 1'b0;
        bus.pmem_addr = '0;
        bus.pmem_d    = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ptr_d   = bus.base_addr;
                    cnt_d   = '0;
                    state_d = (bus.num_rows == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                bus.busy = 1'b1;
                if (bus.ofifo_valid) begin
                    bus.ofifo_rd  = 1'b1;
                    bus.pmem_cen  = 1'b0;
                    bus.pmem_addr = ptr_q;
                    if (acc_q) begin
                        bus.pmem_ren = 1'b1;
                        hold_d       = bus.ofifo_out;
                        state_d      = ADD;
                    end else begin
                        bus.pmem_wen = 1'b0;
                        bus.pmem_d   = wdata;
                        ptr_d        = ptr_q + 1'b1;
                        cnt_d        = cnt_inc;
                        state_d      = (cnt_inc == nrows_q) ? FINISH : FETCH;
                    end
                end
            end
            ADD: begin
                bus.busy      = 1'b1;
                bus.pmem_cen  = 1'b0;
                bus.pmem_wen  = 1'b0;
                bus.pmem_addr = ptr_q;
                bus.pmem_d    = wdata;
                ptr_d         = ptr_q + 1'b1;
                cnt_d         = cnt_inc;
                state_d       = (cnt_inc == nrows_q) ? FINISH : FETCH;
            end
            FINISH: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            nrows_q <= '0;
            acc_q   <= 1'b0;
            relu_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            // Configuration is frozen for the whole tile once accepted.
            if (state_q == IDLE && bus.start) begin
                nrows_q <= bus.num_rows;
                acc_q   <= bus.acc_mode;
                relu_q  <= bus.relu_en;
            end
        end
    end
endmodule

// File: doc/psum_accum_ctrl.md
Name: psum_accum_ctrl

Overview:
Drain engine between the output FIFO and the partial-sum SRAM. On a start command it pops a programmed number of rows from the OFIFO. In accumulate mode it performs a per-row read-modify-write: SRAM psum plus OFIFO row, per lane, saturating. In overwrite mode it writes the OFIFO rows straight into SRAM. ReLU can be applied to the final pass. This replaces hand-sequenced ofifo_rd, CEN_pmem, WEN_pmem and A_pmem instruction bits with one hardware sequence per output tile.

Parameters:
col, 8, lanes (output columns) per row
psum_bw, 16, signed psum width per lane
addr_bw, 11, PSUM SRAM address width

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  one-cycle command pulse; sampled only in IDLE
base_addr  in  addr_bw  first PSUM SRAM row; latched on accepted start
num_rows  in  addr_bw  rows to drain; latched on accepted start
acc_mode  in  1  1 = read-modify-write accumulate, 0 = overwrite; latched on start
relu_en  in  1  1 = clamp negative lanes to 0 before write; latched on start
ofifo_valid  in  1  OFIFO head row available
ofifo_out  in  col*psum_bw  OFIFO head row; combinational while ofifo_valid=1
ofifo_rd  out  1  pop OFIFO head at this posedge
pmem_cen  out  1  SRAM chip enable, active-low
pmem_wen  out  1  SRAM write enable, active-low (0 = write)
pmem_ren  out  1  SRAM read enable, active-high; read data on pmem_q the next cycle
pmem_addr  out  addr_bw  SRAM row address
pmem_d  out  col*psum_bw  SRAM write data
pmem_q  in  col*psum_bw  SRAM read data
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last row is written

Behaviour:
- Reset values: ofifo_rd=0, pmem_cen=1, pmem_wen=1, pmem_ren=0, pmem_addr=0, pmem_d=0, busy=0, done=0. Internal state goes to IDLE; the row counter and latched configuration clear.
- Outputs are registered-state driven. SRAM/FIFO strobes are decoded from state plus ofifo_valid, which is the only combinational path.
- Lane k occupies bits [psum_bw*(k+1)-1 : psum_bw*k].
- States: IDLE, FETCH, ADD, FINISH.
- IDLE:
  - start=1: latch the configuration, set ptr=base_addr and cnt=0.
  - Go to FINISH if num_rows=0, otherwise FETCH.
  - start while not in IDLE is ignored.
- FETCH, ofifo_valid=0: stall. No pop, pmem_cen=1, state held indefinitely.
- FETCH, ofifo_valid=1, acc_mode=1:
  - Assert ofifo_rd; capture ofifo_out into hold_reg.
  - Assert pmem_cen=0, pmem_ren=1, pmem_wen=1, pmem_addr=ptr.
  - Go to ADD.
- FETCH, ofifo_valid=1, acc_mode=0:
  - Assert ofifo_rd and write in the same cycle: pmem_cen=0, pmem_wen=0, pmem_addr=ptr, pmem_d=f(ofifo_out).
  - Advance: ptr++, cnt++. Go to FINISH if cnt+1==num_rows, else stay in FETCH. Throughput is 1 row/cycle.
- ADD (accumulate only):
  - Per lane, compute the signed sum hold_reg + pmem_q in psum_bw+1 bits and saturate to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - Write pmem_d=f(sum): pmem_cen=0, pmem_wen=0, pmem_ren=0, pmem_addr=ptr (same row just read).
  - Advance as above and return to FETCH or go to FINISH. Throughput is 1 row per 2 cycles minimum.
- f(x): with relu_en=1, lanes whose sign bit is set become 0; otherwise x unchanged. ReLU is applied after saturation.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE. A start in the FINISH cycle is ignored.
- Address arithmetic is modulo 2^addr_bw: ptr wraps from 2^addr_bw-1 to 0 without error.
- No SRAM access occurs in IDLE or FINISH. A write never coincides with a read.
- Reset asserted mid-operation:
  - Abort immediately, return to IDLE, deassert all strobes, and do not raise done.
  - A row already popped into hold_reg is discarded.

Test Plan:
- Overwrite: base=5, num_rows=3, acc_mode=0, OFIFO rows with all lanes 1,2,3 and valid held high -> writes at addr 5,6,7 on three consecutive cycles; done 1 cycle after the last write; 3 pops.
- Accumulate: SRAM[10] lanes=100, OFIFO row lanes=-30, base=10, num_rows=1, acc_mode=1 -> read addr 10, next cycle write addr 10 lanes=70; done next cycle.
- Saturation and ReLU:
  - Lane 32000 + 1000 -> 32767; lane -32000 + -1000 -> -32768.
  - Repeat with relu_en=1 -> 32767 and 0.
- Stall and wrap: base=2046, num_rows=3, ofifo_valid low for 4 cycles between rows -> no SRAM activity while stalled; writes to 2046, 2047, 0 in order.
- Boundaries:
  - num_rows=0 -> done 1 cycle after start, no pops or accesses.
  - start pulsed while busy -> ignored, sequence unaffected.
- Reset mid-op: reset asserted in ADD -> next cycle all strobes inactive, busy=0, no done. A new start afterwards completes normally.
